// File: rtl/line_engine_pkg.sv
// Shared types and helpers for the line engine: FSM state encoding, burst
// geometry, the queued command record and the pen-to-byte-mask mapping.
package line_engine_pkg;

    localparam int PIX_PER_BURST   = 8;
    localparam int BEATS_PER_BURST = 2;
    localparam int PIX_PER_BEAT    = PIX_PER_BURST / BEATS_PER_BURST;

    // Widest legal coordinate; the queued record is sized for it and the
    // engine only consumes the low COORD_W bits of each field.
    localparam int COORD_W_MAX = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STEP  = 3'd2,
        ST_BEAT0 = 3'd3,
        ST_BEAT1 = 3'd4
    } le_state_e;

    typedef struct packed {
        logic [COORD_W_MAX-1:0] x0;
        logic [COORD_W_MAX-1:0] y0;
        logic [COORD_W_MAX-1:0] x1;
        logic [COORD_W_MAX-1:0] y1;
        logic [23:0]            color;
    } le_cmd_t;

    // Byte mask for one beat: pixel p%4 of the beat owns bits [15-4*(p%4) -: 4];
    // a set pen bit enables (clears) its nibble.
    function automatic logic [15:0] pix_mask(input logic [7:0] pen, input logic beat);
        logic [3:0] sel;
        sel = beat ? pen[7:4] : pen[3:0];
        return {~{4{sel[0]}}, ~{4{sel[1]}}, ~{4{sel[2]}}, ~{4{sel[3]}}};
    endfunction

endpackage

// File: rtl/line_engine_if.sv
// Bus bundle for the line engine: command push side from the graphics
// command processor and the af/wdf request side of the memory controller.
// master = environment (command source + FIFO status), slave = engine.
interface line_engine_if #(
    parameter int COORD_W = 10
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [31:0]        cmd_color;
    logic [31:0]        frame_base;
    logic               af_full;
    logic               wdf_full;
    logic [30:0]        af_addr_din;
    logic               af_wr_en;
    logic [127:0]       wdf_din;
    logic [15:0]        wdf_mask_din;
    logic               wdf_wr_en;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, frame_base,
        output af_full, wdf_full,
        input  cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, frame_base,
        input  af_full, wdf_full,
        output cmd_ready, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );

endinterface

// File: rtl/line_cmd_fifo.sv
// Small synchronous first-word-fall-through FIFO for queued line commands.
// Pushes while full and pops while empty are ignored.
module line_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/line_engine_q.sv
// Queued Bresenham line engine. Rasterises lines with inclusive endpoints and
// coalesces the pixels that land in one 8-pixel burst into a single masked
// two-beat write through the af/wdf FIFOs.
// Build option: define LE_CLIP_EN to drop pixels outside SCREEN_W x SCREEN_H
// and to skip bursts that end up with no pixel set.
//
//   state | meaning
//   IDLE  | wait for a queued command, pop and latch it with frame_base
//   SETUP | octant fold (steep swap, endpoint swap), init error term
//   STEP  | one pixel per cycle into the burst accumulator
//   BEAT0 | address + first data beat (pixels 0..3), waits on af/wdf full
//   BEAT1 | second data beat (pixels 4..7), waits on wdf full
module line_engine_q
    import line_engine_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int CMD_DEPTH = 4,
    parameter int SCREEN_W  = 800,
    parameter int SCREEN_H  = 600
) (
    input  logic          clk,
    input  logic          rst_n,
    line_engine_if.slave  bus,
    output logic          busy_o
);

    localparam int CW    = COORD_W;
    localparam int EW    = COORD_W + 2;
    localparam int KEY_W = 2 * COORD_W - 3;
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    le_state_e state_q, state_d;

    le_cmd_t push_cmd, pop_cmd;
    logic    fifo_full, fifo_empty, push, pop;
    logic    rdy_en_q;

    logic [CW-1:0] c_x0_q, c_y0_q, c_x1_q, c_y1_q;
    logic [23:0]   color_q;
    logic [5:0]    fb6_q;

    logic [CW-1:0]        x_q, y_q, xe_q;
    logic [CW:0]          dx_q, ady_q;
    logic signed [EW-1:0] err_q;
    logic                 yneg_q, steep_q, last_q, last_d;
    logic [7:0]           pen_q;
    logic [KEY_W-1:0]     key_q;
    logic                 key_vld_q;

    logic ld_setup, set_pen, adv, clr_acc;
    logic af_we, wdf_we;
    logic [15:0] mask;

    // Setup datapath (octant fold of the latched command).
    logic [CW-1:0] s_x0, s_y0, s_x1, s_y1, f_x0, f_y0, f_x1, f_y1;
    logic          steep;

    // Step datapath.
    logic [CW-1:0]        col, row, y_adv;
    logic [KEY_W-1:0]     pix_key;
    logic                 key_hit, at_end;
    logic signed [EW-1:0] err_sub, err_adv;
`ifdef LE_CLIP_EN
    logic                 pix_in;
`endif

    logic unused_bits;
    assign unused_bits = ^{pop_cmd, bus.frame_base, bus.cmd_color, SCREEN_W, SCREEN_H};

    // Pack the incoming command into the queue record.
    always_comb begin
        push_cmd                = '0;
        push_cmd.x0[CW-1:0]     = bus.cmd_x0;
        push_cmd.y0[CW-1:0]     = bus.cmd_y0;
        push_cmd.x1[CW-1:0]     = bus.cmd_x1;
        push_cmd.y1[CW-1:0]     = bus.cmd_y1;
        push_cmd.color          = bus.cmd_color[23:0];
    end

    assign bus.cmd_ready = rdy_en_q && !fifo_full;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    line_cmd_fifo #(
        .WIDTH ($bits(le_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (push_cmd),
        .pop_i   (pop),
        .dout_o  (pop_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Steep swap then left-to-right ordering of the latched endpoints.
    always_comb begin
        steep = abs_diff(c_y1_q, c_y0_q) > abs_diff(c_x1_q, c_x0_q);
        s_x0  = steep ? c_y0_q : c_x0_q;
        s_y0  = steep ? c_x0_q : c_y0_q;
        s_x1  = steep ? c_y1_q : c_x1_q;
        s_y1  = steep ? c_x1_q : c_y1_q;
        if (s_x0 > s_x1) begin
            f_x0 = s_x1; f_y0 = s_y1; f_x1 = s_x0; f_y1 = s_y0;
        end else begin
            f_x0 = s_x0; f_y0 = s_y0; f_x1 = s_x1; f_y1 = s_y1;
        end
    end

    // Current screen pixel, its burst key and the Bresenham advance.
    always_comb begin
        col     = steep_q ? y_q : x_q;
        row     = steep_q ? x_q : y_q;
        pix_key = {row, col[CW-1:3]};
        key_hit = !key_vld_q || (key_q == pix_key);
        at_end  = (x_q == xe_q);
        err_sub = err_q - $signed({1'b0, ady_q});
        err_adv = err_sub;
        y_adv   = y_q;
        if (err_sub[EW-1]) begin
            err_adv = err_sub + $signed({1'b0, dx_q});
            y_adv   = yneg_q ? (y_q - ONE_C) : (y_q + ONE_C);
        end
`ifdef LE_CLIP_EN
        pix_in = ({{(32-CW){1'b0}}, col} < SCREEN_W) && ({{(32-CW){1'b0}}, row} < SCREEN_H);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state, datapath controls and memory strobes.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        pop      = 1'b0;
        ld_setup = 1'b0;
        set_pen  = 1'b0;
        adv      = 1'b0;
        clr_acc  = 1'b0;
        af_we    = 1'b0;
        wdf_we   = 1'b0;
        mask     = 16'hFFFF;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ld_setup = 1'b1;
                state_d  = ST_STEP;
            end
            ST_STEP: begin
`ifdef LE_CLIP_EN
                if (!pix_in) begin
                    if (!at_end) begin
                        adv = 1'b1;
                    end else if (pen_q == 8'h00) begin
                        clr_acc = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        last_d  = 1'b1;
                        state_d = ST_BEAT0;
                    end
                end else
`endif
                if (key_hit) begin
                    set_pen = 1'b1;
                    if (at_end) begin
                        last_d  = 1'b1;
                        state_d = ST_BEAT0;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    // Pixel belongs to another burst: flush, then revisit it.
                    last_d  = 1'b0;
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                mask = pix_mask(pen_q, 1'b0);
                if (!bus.af_full && !bus.wdf_full) begin
                    af_we   = 1'b1;
                    wdf_we  = 1'b1;
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                mask = pix_mask(pen_q, 1'b1);
                if (!bus.wdf_full) begin
                    wdf_we  = 1'b1;
                    clr_acc = 1'b1;
                    state_d = last_q ? ST_IDLE : ST_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // cmd_ready is held low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en_q <= 1'b0;
        else        rdy_en_q <= 1'b1;
    end

    // Command latch, iterator and burst accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_x0_q    <= '0;
            c_y0_q    <= '0;
            c_x1_q    <= '0;
            c_y1_q    <= '0;
            color_q   <= '0;
            fb6_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            xe_q      <= '0;
            dx_q      <= '0;
            ady_q     <= '0;
            err_q     <= '0;
            yneg_q    <= 1'b0;
            steep_q   <= 1'b0;
            last_q    <= 1'b0;
            pen_q     <= '0;
            key_q     <= '0;
            key_vld_q <= 1'b0;
        end else begin
            last_q <= last_d;
            if (pop) begin
                c_x0_q  <= pop_cmd.x0[CW-1:0];
                c_y0_q  <= pop_cmd.y0[CW-1:0];
                c_x1_q  <= pop_cmd.x1[CW-1:0];
                c_y1_q  <= pop_cmd.y1[CW-1:0];
                color_q <= pop_cmd.color;
                fb6_q   <= bus.frame_base[27:22];
            end
            if (ld_setup) begin
                x_q       <= f_x0;
                y_q       <= f_y0;
                xe_q      <= f_x1;
                dx_q      <= {1'b0, f_x1} - {1'b0, f_x0};
                ady_q     <= abs_diff(f_y1, f_y0);
                yneg_q    <= (f_y1 < f_y0);
                steep_q   <= steep;
                err_q     <= $signed({2'b00, f_x1} - {2'b00, f_x0}) >>> 1;
                pen_q     <= '0;
                key_vld_q <= 1'b0;
            end
            if (set_pen) begin
                pen_q[col[2:0]] <= 1'b1;
                key_q           <= pix_key;
                key_vld_q       <= 1'b1;
            end
            if (adv) begin
                x_q   <= x_q + ONE_C;
                y_q   <= y_adv;
                err_q <= err_adv;
            end
            if (clr_acc) begin
                pen_q     <= '0;
                key_vld_q <= 1'b0;
            end
        end
    end

    assign bus.af_addr_din  = 31'({fb6_q, key_q, 2'b00});
    assign bus.af_wr_en     = af_we;
    assign bus.wdf_wr_en    = wdf_we;
    assign bus.wdf_mask_din = mask;
    assign bus.wdf_din      = {4{8'h00, color_q}};
    assign busy_o           = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_line_engine_q.sv
// Directed bench for line_engine_q: hand-computed burst addresses, masks and
// data for a handful of lines, backpressure holds, queue fill and reset abort.
module tb_line_engine_q;
    import line_engine_pkg::*;

    localparam int CW  = 10;
    localparam int FB6 = 'h21;
    localparam logic [31:0] FB = 32'h0840_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    line_engine_if #(.COORD_W(CW)) bus ();

    line_engine_q #(
        .COORD_W   (CW),
        .CMD_DEPTH (4),
        .SCREEN_W  (800),
        .SCREEN_H  (600)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Burst monitor, sampled on the falling edge.
    int             n_af  = 0;
    int             n_wdf = 0;
    logic [30:0]    aq[$];
    logic [15:0]    mq[$];
    logic [127:0]   dq[$];

    always @(negedge clk) begin
        if (bus.af_wr_en) begin
            aq.push_back(bus.af_addr_din);
            n_af++;
        end
        if (bus.wdf_wr_en) begin
            mq.push_back(bus.wdf_mask_din);
            dq.push_back(bus.wdf_din);
            n_wdf++;
        end
    end

    function automatic logic [30:0] a_at(input int i);
        if (i < aq.size()) return aq[i];
        return 'x;
    endfunction

    function automatic logic [15:0] m_at(input int i);
        if (i < mq.size()) return mq[i];
        return 'x;
    endfunction

    function automatic logic [127:0] d_at(input int i);
        if (i < dq.size()) return dq[i];
        return 'x;
    endfunction

    function automatic logic [30:0] exp_addr(input int row, input int blk);
        return 31'((FB6 << 19) | (row << 9) | (blk << 2));
    endfunction

    task automatic clear_mon();
        aq.delete(); mq.delete(); dq.delete();
        n_af  = 0;
        n_wdf = 0;
    endtask

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [31:0] color);
        int n;
        n = 0;
        bus.cmd_x0    = CW'(x0);
        bus.cmd_y0    = CW'(y0);
        bus.cmd_x1    = CW'(x1);
        bus.cmd_y1    = CW'(y1);
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("push_timeout", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= max) chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] diag_m [4];
        int n;
        int base_af;
        diag_m = '{16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0};

        bus.cmd_valid  = 1'b0;
        bus.cmd_x0     = '0;
        bus.cmd_y0     = '0;
        bus.cmd_x1     = '0;
        bus.cmd_y1     = '0;
        bus.cmd_color  = '0;
        bus.frame_base = FB;
        bus.af_full    = 1'b0;
        bus.wdf_full   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_af_wr_en",  bus.af_wr_en, 1'b0);
        chk("rst_wdf_wr_en", bus.wdf_wr_en, 1'b0);
        chk("rst_mask",      bus.wdf_mask_din, 16'hFFFF);
        chk("rst_addr",      bus.af_addr_din, 31'h0);
        chk("rst_din",       bus.wdf_din, 128'h0);
        chk("rst_busy",      busy, 1'b0);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", bus.cmd_ready, 1'b0);
        @(posedge clk); #1;
        chk("rdy_after_edge", bus.cmd_ready, 1'b1);

        // Full horizontal burst
        clear_mon();
        push_cmd(0, 0, 7, 0, 32'h00FF_0000);
        wait_idle(200);
        chk("hline_n_af",  n_af, 1);
        chk("hline_n_wdf", n_wdf, 2);
        chk("hline_addr",  a_at(0), exp_addr(0, 0));
        chk("hline_mask0", m_at(0), 16'h0000);
        chk("hline_mask1", m_at(1), 16'h0000);
        chk("hline_data0", d_at(0), {4{32'h00FF_0000}});
        chk("hline_data1", d_at(1), {4{32'h00FF_0000}});

        // Single point
        clear_mon();
        push_cmd(5, 3, 5, 3, 32'hAA12_3456);
        wait_idle(200);
        chk("point_n_af",  n_af, 1);
        chk("point_n_wdf", n_wdf, 2);
        chk("point_addr",  a_at(0), exp_addr(3, 0));
        chk("point_mask0", m_at(0), 16'hFFFF);
        chk("point_mask1", m_at(1), 16'hF0FF);
        chk("point_data0", d_at(0), {4{32'h0012_3456}});

        // Vertical (steep) line
        clear_mon();
        push_cmd(2, 0, 2, 3, 32'h0000_00FF);
        wait_idle(200);
        chk("vline_n_af", n_af, 4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("vline_addr%0d", r),  a_at(r), exp_addr(r, 0));
            chk($sformatf("vline_mask0_%0d", r), m_at(2*r), 16'hFF0F);
            chk($sformatf("vline_mask1_%0d", r), m_at(2*r+1), 16'hFFFF);
        end

        // Reverse diagonal; frame_base changes while the line is in flight
        clear_mon();
        push_cmd(3, 3, 0, 0, 32'h0001_0203);
        n = 0;
        while (n_af < 1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        bus.frame_base = 32'h0000_0000;
        wait_idle(200);
        bus.frame_base = FB;
        chk("diag_n_af", n_af, 4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("diag_addr%0d", r),  a_at(r), exp_addr(r, 0));
            chk($sformatf("diag_mask0_%0d", r), m_at(2*r), diag_m[r]);
        end

        // Backpressure: af_full held in BEAT0, wdf_full held in BEAT1
        clear_mon();
        bus.af_full = 1'b1;
        push_cmd(1, 4, 5, 4, 32'h00AB_CDEF);
        n = 0;
        while (bus.wdf_mask_din !== 16'hF000 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_beat0", bus.wdf_mask_din, 16'hF000);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_af_hold_strobes", {bus.af_wr_en, bus.wdf_wr_en}, 2'b00);
            chk("bp_af_hold_mask",    bus.wdf_mask_din, 16'hF000);
        end
        bus.af_full = 1'b0;
        @(posedge clk); #1;
        bus.wdf_full = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_wdf_hold_strobes", {bus.af_wr_en, bus.wdf_wr_en}, 2'b00);
            chk("bp_wdf_hold_mask",    bus.wdf_mask_din, 16'h00FF);
        end
        bus.wdf_full = 1'b0;
        wait_idle(200);
        chk("bp_n_af",  n_af, 1);
        chk("bp_n_wdf", n_wdf, 2);
        chk("bp_addr",  a_at(0), exp_addr(4, 0));
        chk("bp_mask0", m_at(0), 16'hF000);
        chk("bp_mask1", m_at(1), 16'h00FF);

        // Queue: long line in flight, then 5 pushes into a depth-4 queue
        clear_mon();
        push_cmd(0, 0, 63, 0, 32'h0011_2233);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            push_cmd(k, 10 + k, k, 10 + k, 32'h0000_0100 + k);
            chk($sformatf("q_ready_after_push%0d", k), bus.cmd_ready, (k < 3) ? 1'b1 : 1'b0);
        end
        push_cmd(4, 14, 4, 14, 32'h0000_0104);
        wait_idle(2000);
        chk("q_n_af", n_af, 13);
        for (int i = 0; i < 8; i++)
            chk($sformatf("q_line_addr%0d", i), a_at(i), exp_addr(0, i));
        for (int k = 0; k < 5; k++)
            chk($sformatf("q_point_addr%0d", k), a_at(8 + k), exp_addr(10 + k, 0));

        // Reset pulse mid-line with commands still queued
        clear_mon();
        push_cmd(0, 5, 63, 5, 32'h0055_5555);
        push_cmd(1, 20, 1, 20, 32'h0000_0001);
        push_cmd(2, 21, 2, 21, 32'h0000_0002);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wdf_wr_en && n < 200);
        chk("rstmid_saw_strobe", bus.wdf_wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_af_wr_en",  bus.af_wr_en, 1'b0);
        chk("rstmid_wdf_wr_en", bus.wdf_wr_en, 1'b0);
        chk("rstmid_mask",      bus.wdf_mask_din, 16'hFFFF);
        chk("rstmid_busy",      busy, 1'b0);
        chk("rstmid_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base_af = n_af;
        repeat (30) @(posedge clk);
        #1;
        chk("rstmid_no_bursts", n_af, base_af);
        chk("rstmid_idle_busy", busy, 1'b0);
        chk("rstmid_ready",     bus.cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_engine_q.md
Name: line_engine_q

Overview:
- Parametrised successor line engine: rasterises queued Bresenham lines (inclusive endpoints) into the DDR framebuffer through the af/wdf FIFO interface.
- Coalesces all line pixels that fall in one 8-pixel, 256-bit burst into a single masked two-beat write.
- Holds correctly under af_full/wdf_full backpressure.
- Sits between the graphics command processor (push side) and the memory-controller request FIFOs.

Parameters:
- COORD_W, 10: bits per coordinate; legal range 4..13, so the address fits in 31 bits.
- CMD_DEPTH, 4: command queue entries; power of two, at least 2.
- SCREEN_W, 800: visible width; used only with LE_CLIP_EN.
- SCREEN_H, 600: visible height; used only with LE_CLIP_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full; a command is accepted on cmd_valid && cmd_ready
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  endpoints
- cmd_color  in  32  pixel colour; only [23:0] is used
- frame_base  in  32  framebuffer byte base
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_addr_din  out  31  burst address
- af_wr_en  out  1  address write strobe
- wdf_din  out  128  write data
- wdf_mask_din  out  16  byte mask; 1 = byte not written
- wdf_wr_en  out  1  data write strobe
- busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (rst_n low, async):
  - Queue emptied, FSM to IDLE.
  - af_wr_en=0, wdf_wr_en=0, wdf_mask_din=16'hFFFF, af_addr_din=0, wdf_din=0, busy=0, cmd_ready=0.
  - cmd_ready goes to 1 on the first clk edge after release.
  - Reset mid-burst aborts immediately, even between beats; the memory controller is reset with it.
- Queue: FIFO of {x0,y0,x1,y1,color}. cmd_ready = !full. Push while full is ignored. Push and pop in the same cycle are both legal.
- FSM states: IDLE, SETUP, STEP, BEAT0, BEAT1.
- IDLE: when the queue is non-empty, pop one entry, latch it and latch frame_base[27:22], then go to SETUP.
- SETUP (1 cycle):
  - steep = |dy| > |dx|. If steep, swap x and y of both endpoints.
  - If x0 > x1, swap the endpoints.
  - dx = x1-x0 (COORD_W+1 bits, unsigned). ady = |y1-y0|. ystep = ±1.
  - err = dx>>1, signed, COORD_W+2 bits. Iterator = (x0,y0).
  - Clear the accumulator: pen[7:0]=0, key invalid. Go to STEP.
- STEP (1 pixel per cycle):
  - Screen pixel is (col,row) = steep ? (y,x) : (x,y). key = {row, col[COORD_W-1:3]}.
  - Key invalid or equal to the stored key: set pen[col[2:0]] and store the key. If x==x1, go to BEAT0 with last=1. Otherwise advance: x+=1, err-=ady; if err<0 then y+=ystep, err+=dx.
  - Key differs: go to BEAT0 with last=0 and do not advance; that pixel is re-evaluated after the flush.
- BEAT0:
  - When !af_full && !wdf_full: pulse af_wr_en and wdf_wr_en for one cycle, then go to BEAT1.
  - Otherwise both strobes stay 0 and the state holds.
  - af_addr_din = {zero pad, fb6, row, col[COORD_W-1:3], 2'b00}.
- BEAT1:
  - When !wdf_full: pulse wdf_wr_en (af_wr_en=0). Then clear pen and the key; go to STEP if last=0, else go to IDLE.
  - Otherwise hold.
- Mask mapping: pixel p in 0..3 is in BEAT0 and p in 4..7 is in BEAT1. Its byte-mask nibble is bits [15-4*(p%4) -: 4], driven 0 when pen[p]=1; all other bits are 1.
- Data: wdf_din = 4 copies of {8'h00, color[23:0]} in both beats.
- Outside BEAT0/BEAT1: af_wr_en=0, wdf_wr_en=0, wdf_mask_din=16'hFFFF.
- A point (x0==x1 and y0==y1) produces exactly one pixel.
- Line length per command = dx+1 pixels; x never wraps.
- frame_base changes mid-line do not affect the line in flight.
- Back-to-back commands: IDLE to SETUP of the next command is 1 cycle after BEAT1 completes.

Optional Feature:
- LE_CLIP_EN defined:
  - Pixels with col >= SCREEN_W or row >= SCREEN_H are not set in pen; the iterator still advances.
  - A flush with pen==0 skips BEAT0/BEAT1 entirely: no strobes, and the FSM goes directly to STEP or IDLE.
- LE_CLIP_EN undefined: every pixel is written; addresses wrap modulo 2^COORD_W.

Decomposition:
- Shared package line_engine_pkg:
  - State enum.
  - PIX_PER_BURST=8, BEATS_PER_BURST=2.
  - Pixel-to-mask function.
  - Command struct typedef parametrised on COORD_W.
- One natural sub-module: line_cmd_fifo, a parametrised sync FIFO (width, depth) with async active-low reset, exposing full/empty.

Test Plan:
- (0,0)-(7,0), color 0x00FF0000:
  - Exactly one burst, row 0, col block 0.
  - BEAT0 mask 16'h0000, BEAT1 mask 16'h0000.
  - wdf_din = 4x 32'h00FF0000.
- Point (5,3)-(5,3):
  - One burst, addr row 3, block 0.
  - BEAT0 mask 16'hFFFF, BEAT1 mask 16'hF0FF.
- Vertical (2,0)-(2,3):
  - Steep path, 4 bursts for rows 0..3.
  - Each BEAT0 mask 16'hFF0F, BEAT1 16'hFFFF.
- Reverse diagonal (3,3)-(0,0):
  - Endpoint swap, 4 bursts for rows 0,1,2,3.
  - BEAT0 masks 16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0.
- Backpressure:
  - af_full=1 for 5 cycles in BEAT0: no strobes, state held.
  - wdf_full=1 for 3 cycles in BEAT1: no strobes, state held.
  - Exactly 1 af_wr_en and 2 wdf_wr_en per burst.
- Queue:
  - 5 back-to-back pushes while busy, CMD_DEPTH=4: cmd_ready drops after the 4th stored entry; all queued lines are drawn in order.
  - rst_n pulse mid-line: strobes fall asynchronously, queue empty, busy=0.
